// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU sequential subtractor: FSM encoding
// and default datapath geometry.
package valu_pkg;

    localparam int VALU_WIDTH = 32;
    localparam int VALU_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } valu_state_e;

endpackage

// File: rtl/valu_csel_slice.sv
// Carry-select adder slice: both carry-in outcomes are precomputed and the
// incoming carry only drives the final mux.
module valu_csel_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] sum0;
    logic [CHUNK:0] sum1;
    logic [CHUNK:0] sum_sel;

    assign sum0    = {1'b0, a} + {1'b0, b};
    assign sum1    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, 1'b1};
    assign sum_sel = cin ? sum1 : sum0;
    assign s       = sum_sel[CHUNK-1:0];
    assign cout    = sum_sel[CHUNK];

endmodule

// File: rtl/valu_sub_seq.sv
// Multi-cycle subtractor: Diff = A + ~B + 1, one CHUNK-bit slice per cycle,
// LSB first, with borrow/overflow/zero flags and valid/ready on both sides.
module valu_sub_seq
    import valu_pkg::*;
#(
    parameter int WIDTH  = VALU_WIDTH,
    parameter int CHUNK  = VALU_CHUNK,
    parameter int NCHUNK = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int CW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB = WIDTH - 1;

    valu_state_e      state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // holds ~B
    logic             carry_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic [CHUNK-1:0] a_sl [NCHUNK];
    logic [CHUNK-1:0] b_sl [NCHUNK];
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] diff_merged;
    logic             last_slice;

    // Slice views of the operands and the result with the current slice
    // spliced in, so the final flags see the complete difference.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_sl[gi] = b_reg[gi*CHUNK +: CHUNK];
            assign diff_merged[gi*CHUNK +: CHUNK] =
                (cnt_reg == CW'(gi)) ? slice_s : diff_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    valu_csel_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_sl[cnt_reg]),
        .b    (b_sl[cnt_reg]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign last_slice = (cnt_reg == CW'(NCHUNK - 1));

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_slice) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= A;
                        b_reg     <= ~B;
                        carry_reg <= 1'b1;
                        cnt_reg   <= '0;
                        diff_reg  <= '0;
                    end
                end
                BUSY: begin
                    diff_reg  <= diff_merged;
                    carry_reg <= slice_cout;
                    if (last_slice) begin
                        bout_reg <= ~slice_cout;
                        // b_reg is ~B, so equal MSBs here mean A and B differ in sign
                        ovf_reg  <= (a_reg[MSB] == b_reg[MSB]) &&
                                    (diff_merged[MSB] != a_reg[MSB]);
                        zero_reg <= (diff_merged == '0);
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Diff = diff_reg;
    assign Bout = bout_reg;
    assign Ovf  = ovf_reg;
    assign Zero = zero_reg;

endmodule
